// File: rtl/pwr_axil_write_arb.sv
// ---------------------------------------------------------------------------
// pwr_axil_write_arb
//
// Write-side AXI-Lite master shared by the two write requesters of the power
// controller: M (maestro power-domain sequencer) and F (observation-fetch
// FSM). Rising edges on the request inputs are captured into per-requester
// pending slots. One single-beat write is issued at a time, with M winning
// over F. Each requester gets a pulse when its request goes onto the bus
// (valid) and a pulse when the B response comes back (ack).
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   m_addr_i/m_data_i    maestro target address / write data
//   m_req_i              maestro request (rising edge counts)
//   m_valid_o, m_ack_o   maestro accepted / completed pulses
//   f_addr_i/f_data_i    fetch-FSM target address / write data
//   f_req_i              fetch-FSM request (rising edge counts)
//   f_valid_o, f_ack_o   fetch accepted / completed pulses
//   err_o                sticky: a B response other than OKAY was seen
//   aw_*, w_*, b_*       AXI-Lite write address, data and response channels
// ---------------------------------------------------------------------------
module pwr_axil_write_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   m_addr_i,
  input  logic [DATA_WIDTH-1:0]   m_data_i,
  input  logic                    m_req_i,
  output logic                    m_valid_o,
  output logic                    m_ack_o,
  input  logic [ADDR_WIDTH-1:0]   f_addr_i,
  input  logic [DATA_WIDTH-1:0]   f_data_i,
  input  logic                    f_req_i,
  output logic                    f_valid_o,
  output logic                    f_ack_o,
  output logic                    err_o,
  output logic [ADDR_WIDTH-1:0]   aw_addr,
  output logic [2:0]              aw_prot,
  output logic                    aw_valid,
  input  logic                    aw_ready,
  output logic [DATA_WIDTH-1:0]   w_data,
  output logic [DATA_WIDTH/8-1:0] w_strb,
  output logic                    w_valid,
  input  logic                    w_ready,
  input  logic [1:0]              b_resp,
  input  logic                    b_valid,
  output logic                    b_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                  m_req_q, f_req_q;
  logic                  m_pend_q, f_pend_q;
  logic [ADDR_WIDTH-1:0] m_addr_q, f_addr_q;
  logic [DATA_WIDTH-1:0] m_data_q, f_data_q;
  logic                  owner_f_q;
  logic                  aw_done_q, w_done_q;

  logic m_edge, f_edge;
  logic aw_hs, w_hs, b_hs;
  logic grant_m, grant_f;
  logic addr_complete, resp_complete;

  assign m_edge = m_req_i & ~m_req_q;
  assign f_edge = f_req_i & ~f_req_q;
  assign aw_hs  = aw_valid & aw_ready;
  assign w_hs   = w_valid & w_ready;
  assign b_hs   = b_valid & b_ready;

  assign aw_prot   = 3'b000;
  assign w_strb    = '1;
  assign m_valid_o = grant_m;
  assign f_valid_o = grant_f;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-cycle control strobes. The grant is decided
  // combinationally from the pending slots so the valid pulse coincides with
  // the IDLE cycle that accepts the request. That IDLE cycle can be the same
  // cycle as the previous ack. AW and W handshake independently; the address
  // phase ends once both have completed, counting a handshake happening in
  // this very cycle.
  always_comb begin
    state_d       = state_q;
    grant_m       = 1'b0;
    grant_f       = 1'b0;
    addr_complete = 1'b0;
    resp_complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (m_pend_q) begin
          grant_m = 1'b1;
          state_d = ADDR;
        end else if (f_pend_q) begin
          grant_f = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
          addr_complete = 1'b1;
          state_d       = RESP;
        end
      end
      RESP: begin
        if (b_hs) begin
          resp_complete = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture. A fresh edge always wins over a grant in the same cycle,
  // so a request arriving while its previous one is being accepted stays
  // pending with the new address/data. The grant below has already taken the
  // old latch contents by then.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_req_q  <= 1'b0;
      f_req_q  <= 1'b0;
      m_pend_q <= 1'b0;
      f_pend_q <= 1'b0;
      m_addr_q <= '0;
      m_data_q <= '0;
      f_addr_q <= '0;
      f_data_q <= '0;
    end else begin
      m_req_q <= m_req_i;
      f_req_q <= f_req_i;
      if (grant_m) begin
        m_pend_q <= 1'b0;
      end
      if (grant_f) begin
        f_pend_q <= 1'b0;
      end
      if (m_edge) begin
        m_pend_q <= 1'b1;
        m_addr_q <= m_addr_i;
        m_data_q <= m_data_i;
      end
      if (f_edge) begin
        f_pend_q <= 1'b1;
        f_addr_q <= f_addr_i;
        f_data_q <= f_data_i;
      end
    end
  end

  // AXI channel drivers. The address and data registers load only on a
  // grant, so they stay stable for the whole transaction. The done flags
  // remember which of AW/W has already handshaken while waiting for the
  // other channel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_addr   <= '0;
      w_data    <= '0;
      aw_valid  <= 1'b0;
      w_valid   <= 1'b0;
      b_ready   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      owner_f_q <= 1'b0;
    end else begin
      if (grant_m | grant_f) begin
        aw_addr   <= grant_m ? m_addr_q : f_addr_q;
        w_data    <= grant_m ? m_data_q : f_data_q;
        owner_f_q <= grant_f;
        aw_valid  <= 1'b1;
        w_valid   <= 1'b1;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (aw_hs) begin
        aw_valid  <= 1'b0;
        aw_done_q <= 1'b1;
      end
      if (w_hs) begin
        w_valid  <= 1'b0;
        w_done_q <= 1'b1;
      end
      if (addr_complete) begin
        b_ready   <= 1'b1;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (resp_complete) begin
        b_ready <= 1'b0;
      end
    end
  end

  // Completion pulses and the sticky error flag. The ack goes to whoever
  // owns the transaction, even on an error response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_ack_o <= 1'b0;
      f_ack_o <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      m_ack_o <= resp_complete & ~owner_f_q;
      f_ack_o <= resp_complete & owner_f_q;
      if (resp_complete && (b_resp != 2'b00)) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwr_axil_write_arb.sv
// ---------------------------------------------------------------------------
// tb_pwr_axil_write_arb
//
// Directed bench for pwr_axil_write_arb. A behavioural model, written from
// the request/grant/handshake rules, predicts every output each cycle. A
// small AXI-Lite slave has programmable ready/response delays. Scenario
// checks with hand-computed literals pin down the timing and ordering.
// ---------------------------------------------------------------------------
module tb_pwr_axil_write_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m_addr_i, m_data_i, f_addr_i, f_data_i;
  logic        m_req_i, f_req_i;
  logic        m_valid_o, m_ack_o, f_valid_o, f_ack_o, err_o;
  logic [31:0] aw_addr, w_data;
  logic [2:0]  aw_prot;
  logic [3:0]  w_strb;
  logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic [1:0]  b_resp;

  pwr_axil_write_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_req_i(m_req_i),
    .m_valid_o(m_valid_o), .m_ack_o(m_ack_o),
    .f_addr_i(f_addr_i), .f_data_i(f_data_i), .f_req_i(f_req_i),
    .f_valid_o(f_valid_o), .f_ack_o(f_ack_o), .err_o(err_o),
    .aw_addr(aw_addr), .aw_prot(aw_prot), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic chk_en = 1'b0;

  // Slave configuration and bookkeeping
  int       aw_delay = 0, w_delay = 0, b_delay = 0;
  logic [1:0] resp_val = 2'b00;
  int       aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  logic     s_aw_got = 1'b0, s_w_got = 1'b0, s_owed = 1'b0;

  // Behavioural model state: phase 0 = no transaction, 1 = address/data
  // outstanding, 2 = waiting for the response.
  logic        mdl_prev [2];
  logic        mdl_pend [2];
  logic [31:0] mdl_laddr [2];
  logic [31:0] mdl_ldata [2];
  logic        mdl_ack [2];
  int          mdl_phase = 0;
  int          mdl_cur = 0;
  logic [31:0] mdl_caddr = '0, mdl_cdata = '0;
  logic        mdl_aw_open = 1'b0, mdl_w_open = 1'b0, mdl_err = 1'b0;
  logic        exp_mv, exp_fv, exp_aw, exp_w, exp_br;

  // Scenario logs
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          ack_who[$];
  int          aw_rises, aw_hi, w_hi, n_m_valid, n_f_valid;
  int          first_fv, first_aw, first_br, m_ack_cyc, f_ack_cyc;
  logic        aw_prev = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic mr, input logic [31:0] ma, input logic [31:0] md,
                               input logic fr, input logic [31:0] fa, input logic [31:0] fd);
    m_req_i  = mr;
    m_addr_i = ma;
    m_data_i = md;
    f_req_i  = fr;
    f_addr_i = fa;
    f_data_i = fd;
    tick();
  endtask

  task automatic clearLog();
    wr_addr.delete();
    wr_data.delete();
    ack_who.delete();
    aw_rises  = 0; aw_hi = 0; w_hi = 0; n_m_valid = 0; n_f_valid = 0;
    first_fv  = -1; first_aw = -1; first_br = -1; m_ack_cyc = -1; f_ack_cyc = -1;
  endtask

  task automatic waitAcks(input int n, input int budget);
    int k = 0;
    while (ack_who.size() < n && k < budget) begin
      tick();
      k++;
    end
    checkOutput("ack_wait", ack_who.size(), n);
    tick();
    tick();
  endtask

  function automatic logic [31:0] qAddr(input int i);
    return (i < wr_addr.size()) ? wr_addr[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] qData(input int i);
    return (i < wr_data.size()) ? wr_data[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic int qWho(input int i);
    return (i < ack_who.size()) ? ack_who[i] : -1;
  endfunction

  // Slave drive: ready after the programmed number of cycles, response once
  // both AW and W have been accepted.
  initial begin
    aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      aw_ready = rst_n && aw_valid && (aw_cnt >= aw_delay);
      w_ready  = rst_n && w_valid && (w_cnt >= w_delay);
      b_valid  = rst_n && s_owed && (b_cnt >= b_delay);
      b_resp   = b_valid ? resp_val : 2'b00;
    end
  end

  // Per-cycle compare against the model, scenario logging, then advance the
  // model and slave bookkeeping with the inputs seen in this cycle.
  always @(negedge clk) begin
    cyc++;
    exp_mv = (mdl_phase == 0) && mdl_pend[0];
    exp_fv = (mdl_phase == 0) && mdl_pend[1] && !mdl_pend[0];
    exp_aw = (mdl_phase == 1) && mdl_aw_open;
    exp_w  = (mdl_phase == 1) && mdl_w_open;
    exp_br = (mdl_phase == 2);
    if (chk_en) begin
      checkOutput("m_valid_o", m_valid_o, exp_mv);
      checkOutput("f_valid_o", f_valid_o, exp_fv);
      checkOutput("m_ack_o", m_ack_o, mdl_ack[0]);
      checkOutput("f_ack_o", f_ack_o, mdl_ack[1]);
      checkOutput("err_o", err_o, mdl_err);
      checkOutput("aw_valid", aw_valid, exp_aw);
      checkOutput("w_valid", w_valid, exp_w);
      checkOutput("b_ready", b_ready, exp_br);
      checkOutput("aw_prot", aw_prot, 3'b000);
      if (exp_aw) checkOutput("aw_addr", aw_addr, mdl_caddr);
      if (exp_w) begin
        checkOutput("w_data", w_data, mdl_cdata);
        checkOutput("w_strb", w_strb, 4'hF);
      end
    end

    if (aw_valid && !aw_prev) begin
      aw_rises++;
      if (first_aw < 0) first_aw = cyc;
    end
    aw_prev = aw_valid;
    if (aw_valid) aw_hi++;
    if (w_valid) w_hi++;
    if (b_ready && first_br < 0) first_br = cyc;
    if (m_valid_o) n_m_valid++;
    if (f_valid_o) begin
      n_f_valid++;
      if (first_fv < 0) first_fv = cyc;
    end
    if (aw_valid && aw_ready) wr_addr.push_back(aw_addr);
    if (w_valid && w_ready) wr_data.push_back(w_data);
    if (m_ack_o) begin ack_who.push_back(0); m_ack_cyc = cyc; end
    if (f_ack_o) begin ack_who.push_back(1); f_ack_cyc = cyc; end

    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mdl_prev[k] = 1'b0; mdl_pend[k] = 1'b0; mdl_ack[k] = 1'b0;
      end
      mdl_phase = 0; mdl_aw_open = 1'b0; mdl_w_open = 1'b0; mdl_err = 1'b0;
    end else begin
      mdl_ack[0] = 1'b0;
      mdl_ack[1] = 1'b0;
      if (mdl_phase == 0) begin
        if (mdl_pend[0] || mdl_pend[1]) begin
          mdl_cur   = mdl_pend[0] ? 0 : 1;
          mdl_pend[mdl_cur] = 1'b0;
          mdl_caddr = mdl_laddr[mdl_cur];
          mdl_cdata = mdl_ldata[mdl_cur];
          mdl_aw_open = 1'b1;
          mdl_w_open  = 1'b1;
          mdl_phase   = 1;
        end
      end else if (mdl_phase == 1) begin
        if (mdl_aw_open && aw_ready) mdl_aw_open = 1'b0;
        if (mdl_w_open && w_ready) mdl_w_open = 1'b0;
        if (!mdl_aw_open && !mdl_w_open) mdl_phase = 2;
      end else begin
        if (b_valid) begin
          mdl_ack[mdl_cur] = 1'b1;
          if (b_resp != 2'b00) mdl_err = 1'b1;
          mdl_phase = 0;
        end
      end
      if (m_req_i && !mdl_prev[0]) begin
        mdl_pend[0] = 1'b1; mdl_laddr[0] = m_addr_i; mdl_ldata[0] = m_data_i;
      end
      if (f_req_i && !mdl_prev[1]) begin
        mdl_pend[1] = 1'b1; mdl_laddr[1] = f_addr_i; mdl_ldata[1] = f_data_i;
      end
      mdl_prev[0] = m_req_i;
      mdl_prev[1] = f_req_i;
    end

    if (!rst_n) begin
      aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      s_aw_got = 1'b0; s_w_got = 1'b0; s_owed = 1'b0;
    end else begin
      if (b_valid && b_ready) begin
        s_owed = 1'b0; b_cnt = 0;
      end else if (s_owed) begin
        b_cnt++;
      end
      if (aw_valid && aw_ready) begin aw_cnt = 0; s_aw_got = 1'b1; end
      else if (aw_valid) aw_cnt++;
      else aw_cnt = 0;
      if (w_valid && w_ready) begin w_cnt = 0; s_w_got = 1'b1; end
      else if (w_valid) w_cnt++;
      else w_cnt = 0;
      if (s_aw_got && s_w_got) begin
        s_owed = 1'b1; b_cnt = 0; s_aw_got = 1'b0; s_w_got = 1'b0;
      end
    end
  end

  // Directed scenarios
  initial begin
    int k;
    rst_n = 1'b0;
    m_req_i = 1'b0; f_req_i = 1'b0;
    m_addr_i = '0; m_data_i = '0; f_addr_i = '0; f_data_i = '0;
    clearLog();
    tick();
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    checkOutput("rst_aw_valid", aw_valid, 1'b0);
    checkOutput("rst_b_ready", b_ready, 1'b0);
    checkOutput("rst_err_o", err_o, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single F pulse with a zero-wait slave
    clearLog();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h2000_000C, 32'h0000_00A5);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    waitAcks(1, 40);
    checkOutput("s1_addr", qAddr(0), 32'h2000_000C);
    checkOutput("s1_data", qData(0), 32'h0000_00A5);
    checkOutput("s1_who", qWho(0), 1);
    checkOutput("s1_aw_after_valid", first_aw - first_fv, 1);
    checkOutput("s1_ack_after_valid", f_ack_cyc - first_fv, 3);
    checkOutput("s1_no_m_valid", n_m_valid, 0);

    // M and F rise together: M first, F next, acks 3 cycles apart
    clearLog();
    applyStimulus(1'b1, 32'h10, 32'h11, 1'b1, 32'h20, 32'h22);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    waitAcks(2, 40);
    checkOutput("s2_addr0", qAddr(0), 32'h10);
    checkOutput("s2_addr1", qAddr(1), 32'h20);
    checkOutput("s2_data1", qData(1), 32'h22);
    checkOutput("s2_who0", qWho(0), 0);
    checkOutput("s2_who1", qWho(1), 1);
    checkOutput("s2_ack_gap", f_ack_cyc - m_ack_cyc, 3);

    // M held high for 20 cycles: exactly one write
    clearLog();
    for (k = 0; k < 20; k++) applyStimulus(1'b1, 32'h30, 32'h33, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    repeat (5) tick();
    checkOutput("s3_writes", aw_rises, 1);
    checkOutput("s3_acks", ack_who.size(), 1);
    checkOutput("s3_addr", qAddr(0), 32'h30);

    // Slow slave: AW ready after 3 cycles, W ready after 1
    clearLog();
    aw_delay = 3; w_delay = 1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h40, 32'h44);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    waitAcks(1, 40);
    aw_delay = 0; w_delay = 0;
    checkOutput("s4_aw_hi", aw_hi, 4);
    checkOutput("s4_w_hi", w_hi, 2);
    checkOutput("s4_bready_after_aw", first_br - first_aw, 4);
    checkOutput("s4_addr", qAddr(0), 32'h40);

    // SLVERR still acks and sets the sticky error
    clearLog();
    resp_val = 2'b10;
    applyStimulus(1'b1, 32'h50, 32'h55, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    waitAcks(1, 40);
    resp_val = 2'b00;
    checkOutput("s5_who", qWho(0), 0);
    checkOutput("s5_err", err_o, 1'b1);
    clearLog();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h60, 32'h66);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    waitAcks(1, 40);
    checkOutput("s5_err_sticky", err_o, 1'b1);

    // Reset while waiting for B with F pending: no ack, no later write
    clearLog();
    b_delay = 5;
    applyStimulus(1'b1, 32'h70, 32'h77, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h74, 32'h7A);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    k = 0;
    while (!b_ready && k < 20) begin
      tick();
      k++;
    end
    checkOutput("s6_reached_resp", b_ready, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("s6_rst_aw_valid", aw_valid, 1'b0);
    checkOutput("s6_rst_b_ready", b_ready, 1'b0);
    checkOutput("s6_rst_f_valid", f_valid_o, 1'b0);
    checkOutput("s6_rst_err", err_o, 1'b0);
    checkOutput("s6_rst_aw_addr", aw_addr, 32'h0);
    tick();
    b_delay = 0;
    clearLog();
    rst_n = 1'b1;
    repeat (15) tick();
    checkOutput("s6_no_write", aw_rises, 0);
    checkOutput("s6_no_ack", ack_who.size(), 0);
    checkOutput("s6_no_f_valid", n_f_valid, 0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h80, 32'h88);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    waitAcks(1, 40);
    checkOutput("s6_after_addr", qAddr(0), 32'h80);
    checkOutput("s6_after_who", qWho(0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
